// File: rtl/clk_divider_nch.sv
// NUM_CH independent glitch-free integer clock dividers (any N >= 2) with clk_in-domain tick strobes.
// Ratio reloads and enable changes land only on period wraps; an invalid applied ratio parks the channel.
module clk_divider_nch #(
  parameter int COUNTER_WIDTH = 8,
  parameter int NUM_CH        = 4,
  parameter int RESET_DIV     = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               en,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0] div_N,
  input  logic                            load,
  output logic [NUM_CH-1:0]               clk_out,
  output logic [NUM_CH-1:0]               tick,
  output logic [NUM_CH-1:0]               pend,
  output logic [NUM_CH-1:0]               cfg_err
);
  localparam int W = COUNTER_WIDTH;
  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] TWO       = W'(2);
  localparam logic [W-1:0] RST_RATIO = W'(RESET_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t       state_q, state_d;
    logic [W-1:0] phase_q, phase_d;
    logic [W-1:0] ratio_q, ratio_d;
    logic [W-1:0] pratio_q, pratio_d;
    logic         pend_q, pend_d;
    logic         err_q, err_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic [W-1:0] high_len;
    logic [W-1:0] phase_inc;
    logic         wrap;
    logic         apply;

    // ceil(N/2) without widening, so N = 2^W-1 does not overflow
    assign high_len  = (ratio_q >> 1) + {{(W-1){1'b0}}, ratio_q[0]};
    assign phase_inc = phase_q + ONE;
    assign wrap      = (state_q == RUN) && (phase_q == ratio_q - ONE);
    assign apply     = pend_q && ((state_q == IDLE) || wrap);

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= IDLE;
        phase_q  <= '0;
        ratio_q  <= RST_RATIO;
        pratio_q <= RST_RATIO;
        pend_q   <= 1'b0;
        err_q    <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        phase_q  <= phase_d;
        ratio_q  <= ratio_d;
        pratio_q <= pratio_d;
        pend_q   <= pend_d;
        err_q    <= err_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      ratio_d  = ratio_q;
      pratio_d = pratio_q;
      pend_d   = pend_q;
      err_d    = err_q;
      clk_d    = 1'b0;
      tick_d   = 1'b0;

      // The wrap consumes the value held before this edge; a same-edge load stays pending.
      if (apply) begin
        ratio_d = pratio_q;
        pend_d  = 1'b0;
        if (pratio_q < TWO) err_d = 1'b1;
      end
      if (load) begin
        pratio_d = div_N[c*W +: W];
        pend_d   = 1'b1;
      end

      case (state_q)
        IDLE: begin
          phase_d = '0;
          if (en[c] && (ratio_d >= TWO)) begin
            state_d = RUN;
            clk_d   = 1'b1;
            tick_d  = 1'b1;
          end
        end
        RUN: begin
          if (wrap) begin
            phase_d = '0;
            if (en[c] && (ratio_d >= TWO)) begin
              clk_d  = 1'b1;
              tick_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            phase_d = phase_inc;
            clk_d   = (phase_inc < high_len);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign clk_out[c] = clk_q;
    assign tick[c]    = tick_q;
    assign pend[c]    = pend_q;
    assign cfg_err[c] = err_q;
  end

endmodule

// File: tb/tb_clk_divider_nch.sv
// Scoreboard bench for clk_divider_nch: stimulus queues expected periods and timed output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_clk_divider_nch;
  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int CLK_S = 0;
  localparam int TCK_S = 1;
  localparam int PND_S = 2;
  localparam int ERR_S = 3;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic [NCH-1:0]   en     = '0;
  logic [NCH*W-1:0] div_N  = '0;
  logic             load   = 1'b0;
  logic [NCH-1:0]   clk_out, tick, pend, cfg_err;

  clk_divider_nch #(.COUNTER_WIDTH(W), .NUM_CH(NCH), .RESET_DIV(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .div_N(div_N), .load(load),
    .clk_out(clk_out), .tick(tick), .pend(pend), .cfg_err(cfg_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int per; int hi; } per_t;
  typedef struct { int cyc; int sel; logic [NCH-1:0] mask; logic [NCH-1:0] val; } snap_t;

  per_t  exp_per [NCH][$];
  snap_t snap_q [$];
  string snap_nm [$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    tmo = 0;
  bit    done = 1'b0;

  // Monitor: sole owner of the comparison counters.
  bit mon [NCH];
  int mcnt [NCH];
  int mhi [NCH];
  always @(negedge clk_in) begin
    snap_t s;
    string nm;
    per_t e;
    logic [NCH-1:0] act;
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      s  = snap_q.pop_front();
      nm = snap_nm.pop_front();
      case (s.sel)
        CLK_S:   act = clk_out;
        TCK_S:   act = tick;
        PND_S:   act = pend;
        default: act = cfg_err;
      endcase
      n_checks++;
      if (s.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: snapshot missed (due cycle %0d, now %0d)", nm, s.cyc, cyc);
      end else if ((act & s.mask) !== (s.val & s.mask)) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (mask %b) at cycle %0d", nm, act & s.mask, s.val & s.mask, s.mask, cyc);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (tick[c] && (mon[c] || exp_per[c].size() > 0)) begin
        if (mon[c] && exp_per[c].size() > 0) begin
          e = exp_per[c].pop_front();
          n_checks += 2;
          if (mcnt[c] != e.per) begin
            n_fail++;
            $display("FAIL period_ch%0d: got %0d cycles expected %0d at cycle %0d", c, mcnt[c], e.per, cyc);
          end
          if (mhi[c] != e.hi) begin
            n_fail++;
            $display("FAIL high_ch%0d: got %0d cycles expected %0d at cycle %0d", c, mhi[c], e.hi, cyc);
          end
        end
        mon[c]  = (exp_per[c].size() > 0);
        mcnt[c] = 1;
        mhi[c]  = clk_out[c] ? 1 : 0;
      end else if (mon[c]) begin
        mcnt[c]++;
        mhi[c] += clk_out[c] ? 1 : 0;
      end
    end
    if (done || cyc > 20000) begin
      n_checks++;
      if (cyc > 20000) begin
        n_fail++;
        $display("FAIL watchdog: stimulus still running at cycle %0d, limit 20000", cyc);
      end else if (tmo != 0) begin
        n_fail++;
        $display("FAIL timeouts: got %0d expired waits expected 0", tmo);
      end
      n_checks++;
      if (snap_q.size() != 0) begin
        n_fail++;
        $display("FAIL snap_drain: got %0d pending snapshots expected 0", snap_q.size());
      end
      for (int c = 0; c < NCH; c++) begin
        n_checks++;
        if (exp_per[c].size() != 0) begin
          n_fail++;
          $display("FAIL per_drain_ch%0d: got %0d unchecked periods expected 0", c, exp_per[c].size());
        end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
    cyc++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // j = number of further rising edges after which the outputs are sampled
  task automatic expect_at(input int j, input int sel, input logic [NCH-1:0] mask,
                           input logic [NCH-1:0] val, input string nm);
    snap_t s;
    s.cyc = cyc + j; s.sel = sel; s.mask = mask; s.val = val;
    snap_q.push_back(s);
    snap_nm.push_back(nm);
  endtask

  task automatic push_per(input int c, input int n, input int per, input int hi);
    per_t e;
    e.per = per; e.hi = hi;
    repeat (n) exp_per[c].push_back(e);
  endtask

  function automatic bit any_pending();
    if (snap_q.size() > 0) return 1'b1;
    for (int c = 0; c < NCH; c++) if (exp_per[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget, input string nm);
    int k;
    k = 0;
    while (k < budget && any_pending()) begin
      step();
      k++;
    end
    if (any_pending()) begin
      $display("FAIL %s: scoreboard not drained within %0d cycles", nm, budget);
      tmo++;
      snap_q.delete();
      snap_nm.delete();
      for (int c = 0; c < NCH; c++) exp_per[c].delete();
    end
  endtask

  task automatic wait_tick(input int c, input int budget, input string nm);
    int k;
    k = 0;
    step();
    while (tick[c] !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    if (tick[c] !== 1'b1) begin
      $display("FAIL %s: no tick on channel %0d within %0d cycles", nm, c, budget);
      tmo++;
    end
  endtask

  initial begin
    expect_at(0, CLK_S, 4'hF, 4'h0, "rst_clk");
    expect_at(0, TCK_S, 4'hF, 4'h0, "rst_tick");
    expect_at(0, PND_S, 4'hF, 4'h0, "rst_pend");
    expect_at(0, ERR_S, 4'hF, 4'h0, "rst_err");
    step();

    // Reset ratio 2 on channel 0 only
    rst_n = 1'b1;
    en    = 4'b0001;
    expect_at(1, CLK_S, 4'hF, 4'b0001, "t1_start_clk");
    expect_at(1, TCK_S, 4'hF, 4'b0001, "t1_start_tick");
    expect_at(2, CLK_S, 4'hF, 4'b0000, "t1_low");
    expect_at(2, TCK_S, 4'hF, 4'b0000, "t1_low_tick");
    expect_at(3, CLK_S, 4'hF, 4'b0001, "t1_high2");
    push_per(0, 6, 2, 1);
    drain(100, "t1");
    en = '0;
    step(3);
    expect_at(0, CLK_S, 4'hF, 4'h0, "t1_stopped");

    // Mixed ratios, including odd and the maximum
    div_N = {8'd255, 8'd3, 8'd8, 8'd9};
    load  = 1'b1;
    step();
    load = 1'b0;
    expect_at(0, PND_S, 4'hF, 4'hF, "t2_pend_set");
    en = 4'hF;
    expect_at(1, CLK_S, 4'hF, 4'hF, "t2_start_clk");
    expect_at(1, TCK_S, 4'hF, 4'hF, "t2_start_tick");
    expect_at(1, PND_S, 4'hF, 4'h0, "t2_pend_applied");
    push_per(0, 10, 9, 5);
    push_per(1, 10, 8, 4);
    push_per(2, 10, 3, 2);
    push_per(3, 10, 255, 128);
    drain(3000, "t2");

    // Reload ch0 9 -> 4 at phase 3: the running period completes first
    wait_tick(0, 20, "t3_sync");
    push_per(0, 1, 9, 5);
    push_per(0, 4, 4, 2);
    step(3);
    div_N = {8'd255, 8'd3, 8'd8, 8'd4};
    load  = 1'b1;
    step();
    load = 1'b0;
    expect_at(0, PND_S, 4'b0001, 4'b0001, "t3_pend_held");
    expect_at(4, PND_S, 4'b0001, 4'b0001, "t3_pend_before_wrap");
    expect_at(5, PND_S, 4'b0001, 4'b0000, "t3_pend_fall");
    expect_at(5, TCK_S, 4'b0001, 4'b0001, "t3_wrap_tick");
    drain(200, "t3");

    // Disable ch1 (N=8) during its high phase
    wait_tick(1, 20, "t4_sync");
    step();
    en = 4'b1101;
    expect_at(1, CLK_S, 4'b0010, 4'b0010, "t4_high_p2");
    expect_at(2, CLK_S, 4'b0010, 4'b0010, "t4_high_p3");
    expect_at(3, CLK_S, 4'b0010, 4'b0000, "t4_low_p4");
    expect_at(6, CLK_S, 4'b0010, 4'b0000, "t4_low_p7");
    expect_at(7, TCK_S, 4'b0010, 4'b0000, "t4_no_tick_at_wrap");
    expect_at(7, CLK_S, 4'b0010, 4'b0000, "t4_idle_clk");
    expect_at(11, CLK_S, 4'b0010, 4'b0000, "t4_idle_hold");
    step(12);
    en = 4'hF;
    expect_at(1, CLK_S, 4'b0010, 4'b0010, "t4_restart_clk");
    expect_at(1, TCK_S, 4'b0010, 4'b0010, "t4_restart_tick");
    push_per(1, 3, 8, 4);
    drain(100, "t4");

    // Invalid ratio 1 on ch2, then recovery at 6 with a sticky error
    wait_tick(2, 20, "t5_sync");
    div_N = {8'd255, 8'd1, 8'd8, 8'd4};
    load  = 1'b1;
    step();
    load = 1'b0;
    expect_at(0, CLK_S, 4'b0100, 4'b0100, "t5_high");
    expect_at(0, PND_S, 4'b0100, 4'b0100, "t5_pend");
    expect_at(1, ERR_S, 4'b0100, 4'b0000, "t5_err_not_yet");
    expect_at(2, ERR_S, 4'hF, 4'b0100, "t5_err_set");
    expect_at(2, CLK_S, 4'b0100, 4'b0000, "t5_clk_zero");
    expect_at(2, PND_S, 4'b0100, 4'b0000, "t5_pend_clr");
    expect_at(8, CLK_S, 4'b0100, 4'b0000, "t5_held_low");
    expect_at(8, TCK_S, 4'b0100, 4'b0000, "t5_no_tick");
    step(10);
    div_N = {8'd255, 8'd6, 8'd8, 8'd4};
    load  = 1'b1;
    step();
    load = 1'b0;
    expect_at(0, CLK_S, 4'b0100, 4'b0000, "t5_idle_on_load");
    expect_at(1, CLK_S, 4'b0100, 4'b0100, "t5_restart");
    expect_at(1, ERR_S, 4'b0100, 4'b0100, "t5_err_sticky");
    push_per(2, 4, 6, 3);
    drain(100, "t5");
    expect_at(0, ERR_S, 4'hF, 4'b0100, "t5_err_end");
    step();

    // Reset in the middle of a high phase
    wait_tick(1, 20, "t6_sync");
    step(2);
    rst_n = 1'b0;
    expect_at(0, CLK_S, 4'hF, 4'h0, "t6_rst_clk");
    expect_at(0, TCK_S, 4'hF, 4'h0, "t6_rst_tick");
    expect_at(0, PND_S, 4'hF, 4'h0, "t6_rst_pend");
    expect_at(0, ERR_S, 4'hF, 4'h0, "t6_rst_err");
    step(2);
    en = '0;
    step();
    rst_n = 1'b1;
    step(2);
    expect_at(0, CLK_S, 4'hF, 4'h0, "t6_idle_after");

    // Reset landing on a load edge that is also a wrap edge
    en = 4'hF;
    step(2);
    div_N = {4{8'd5}};
    load  = 1'b1;
    @(posedge clk_in);
    rst_n = 1'b0;
    #1;
    load = 1'b0;
    expect_at(0, CLK_S, 4'hF, 4'h0, "t6b_clk");
    expect_at(0, TCK_S, 4'hF, 4'h0, "t6b_tick");
    expect_at(0, PND_S, 4'hF, 4'h0, "t6b_pend");
    step(2);
    rst_n = 1'b1;
    expect_at(1, CLK_S, 4'hF, 4'hF, "t6b_start");
    expect_at(1, PND_S, 4'hF, 4'h0, "t6b_pend_after");
    for (int c = 0; c < NCH; c++) push_per(c, 3, 2, 1);
    drain(100, "t6");
    done = 1'b1;
  end

endmodule
